// File: rtl/dvi_input_packer.sv
// DVI pixel stream to 1-bpp frame buffer packer.
// Thresholds pixels, packs 8 px/byte MSB-first and keeps every LINE_DECIM-th line.
module dvi_input_packer #(
    parameter int          H_ACTIVE       = 640,
    parameter logic [14:0] BYTES_PER_LINE = 15'h0050,
    parameter logic [14:0] LINES_STORED   = 15'h00F0,
    parameter int          LINE_DECIM     = 2,
    parameter logic [7:0]  THRESHOLD      = 8'h80
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        de,
    input  logic        vs,
    input  logic [7:0]  pix_in,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [10:0] LP_HACT  = 11'(H_ACTIVE);
    localparam logic [9:0]  LP_DECIM = 10'(LINE_DECIM);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vs_q;
    logic        r_de_q;
    logic [10:0] r_pix_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_byte_idx;
    logic [9:0]  r_line_idx;
    logic [14:0] r_line_base;
    logic [14:0] r_stored_cnt;
    logic [7:0]  r_sreg;
    logic        r_wr_en;
    logic [14:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_frame_done;
    logic        r_overrun;

    logic        w_vs_rise;
    logic        w_de_fall;
    logic        w_keep;
    logic        w_bit;
    logic        w_take;
    logic [7:0]  w_sreg_nx;
    logic [3:0]  w_shamt;
    logic [7:0]  w_flush;
    logic [14:0] w_addr;

    assign w_vs_rise = vs & ~r_vs_q;
    assign w_de_fall = ~de & r_de_q;
    assign w_keep    = (r_line_idx % LP_DECIM) == 10'd0;
    assign w_bit     = pix_in >= THRESHOLD;
    assign w_take    = (r_state == CAPTURE) && de && w_keep
                    && (r_pix_cnt < LP_HACT);
    assign w_sreg_nx = {r_sreg[6:0], w_bit};
    // Partial byte holds bit_cnt bits right-aligned; left-align with zero pad.
    assign w_shamt   = 4'd8 - {1'b0, r_bit_cnt};
    assign w_flush   = r_sreg << w_shamt;
    assign w_addr    = r_line_base + {7'd0, r_byte_idx};

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= WAIT_VS;
            r_vs_q       <= 1'b0;
            r_de_q       <= 1'b0;
            r_pix_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_byte_idx   <= '0;
            r_line_idx   <= '0;
            r_line_base  <= '0;
            r_stored_cnt <= '0;
            r_sreg       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_vs_q       <= vs;
            r_de_q       <= de;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_vs_rise) begin
                if (r_state == CAPTURE) r_overrun <= 1'b1;
                r_pix_cnt    <= '0;
                r_bit_cnt    <= '0;
                r_byte_idx   <= '0;
                r_line_idx   <= '0;
                r_line_base  <= '0;
                r_stored_cnt <= '0;
                r_sreg       <= '0;
                r_state      <= CAPTURE;
            end else if (r_state == CAPTURE) begin
                if (w_take) begin
                    r_sreg    <= w_sreg_nx;
                    r_pix_cnt <= r_pix_cnt + 11'd1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_wr_en    <= 1'b1;
                        r_wr_data  <= w_sreg_nx;
                        r_wr_addr  <= w_addr;
                        r_byte_idx <= r_byte_idx + 8'd1;
                    end
                end else if (w_de_fall) begin
                    if (r_bit_cnt != 3'd0) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_flush;
                        r_wr_addr <= w_addr;
                    end
                    r_pix_cnt  <= '0;
                    r_bit_cnt  <= '0;
                    r_byte_idx <= '0;
                    r_sreg     <= '0;
                    if (r_line_idx != 10'h3FF)
                        r_line_idx <= r_line_idx + 10'd1;
                    if (w_keep) begin
                        r_line_base  <= r_line_base + BYTES_PER_LINE;
                        r_stored_cnt <= r_stored_cnt + 15'd1;
                        if (r_stored_cnt + 15'd1 == LINES_STORED) begin
                            r_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end
            end
        end
    end

endmodule
